// File: rtl/spi_flash_model_pkg.sv
// Shared opcodes, field widths and enums for the synthesisable SPI flash responder.
package spi_flash_model_pkg;

    localparam logic [7:0] CmdReadJedec  = 8'h9F;
    localparam logic [7:0] CmdReadStatus = 8'h05;
    localparam logic [7:0] CmdRead       = 8'h03;

    localparam int unsigned CmdBits  = 8;
    localparam int unsigned AddrBits = 24;
    localparam int unsigned ByteBits = 8;
    localparam int unsigned CntW     = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } state_e;

    typedef enum logic [1:0] {
        SRC_JEDEC,
        SRC_STATUS,
        SRC_MEM
    } src_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {3{ResetVal}};
        end else begin
            sr <= {sr[1:0], d};
        end
    end

    assign q      = sr[1];
    assign rise_c = sr[1] & ~sr[2];
    assign fall_c = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_flash_model.sv
// SPI flash responder: oversamples the host SPI bus on clk_i and answers JEDEC ID,
// read-status and read commands from a backdoor-loaded byte array.
module spi_flash_model
    import spi_flash_model_pkg::*;
#(
    parameter int unsigned MemBytes  = 65536,
    parameter int unsigned AddrW     = $clog2(MemBytes),
    parameter logic [23:0] JedecId   = 24'hEF4018,
    parameter logic [7:0]  StatusVal = 8'h00
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sck_i,
    input  logic             cs_ni,
    input  logic             copi_i,
    output logic             cipo_o,
    output logic             cipo_en_o,
    input  logic             mem_we_i,
    input  logic [AddrW-1:0] mem_addr_i,
    input  logic [7:0]       mem_wdata_i,
    output logic             busy_o,
    output logic [7:0]       last_cmd_o,
    output logic             cmd_err_o
);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [1:0] copi_sr;
    logic copi_s;

    spi_sync_edge #(.ResetVal(1'b0)) u_sck_sync (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .d      (sck_i),
        .q      (sck_s),
        .rise_c (sck_rise),
        .fall_c (sck_fall)
    );

    // cs resets to the "selected" level so a cs already low at reset release makes no fall edge
    spi_sync_edge #(.ResetVal(1'b0)) u_cs_sync (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .d      (cs_ni),
        .q      (cs_s),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            copi_sr <= 2'b00;
        end else begin
            copi_sr <= {copi_sr[0], copi_i};
        end
    end
    assign copi_s = copi_sr[1];

    logic [7:0] mem [MemBytes];

    always_ff @(posedge clk_i) begin
        if (mem_we_i) begin
            mem[mem_addr_i] <= mem_wdata_i;
        end
    end

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [AddrBits-2:0] in_sr_q, in_sr_d;
    logic [AddrBits-1:0] rx_word;
    logic [AddrW-1:0]  ptr_q, ptr_d;
    logic [1:0]        jedec_idx_q, jedec_idx_d;
    logic              fetch_q, fetch_d;
    logic              load_q, load_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        rd_byte;
    logic [7:0]        out_sr_q, out_sr_d;
    logic              cipo_d, cipo_en_d, busy_d, cmd_err_d;
    logic [7:0]        last_cmd_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            src_q       <= SRC_JEDEC;
            bit_cnt_q   <= '0;
            in_sr_q     <= '0;
            ptr_q       <= '0;
            jedec_idx_q <= '0;
            fetch_q     <= 1'b0;
            load_q      <= 1'b0;
            byte_q      <= '0;
            out_sr_q    <= '0;
            cipo_o      <= 1'b0;
            cipo_en_o   <= 1'b0;
            busy_o      <= 1'b0;
            last_cmd_o  <= 8'h00;
            cmd_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            bit_cnt_q   <= bit_cnt_d;
            in_sr_q     <= in_sr_d;
            ptr_q       <= ptr_d;
            jedec_idx_q <= jedec_idx_d;
            fetch_q     <= fetch_d;
            load_q      <= load_d;
            byte_q      <= byte_d;
            out_sr_q    <= out_sr_d;
            cipo_o      <= cipo_d;
            cipo_en_o   <= cipo_en_d;
            busy_o      <= busy_d;
            last_cmd_o  <= last_cmd_d;
            cmd_err_o   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        bit_cnt_d   = bit_cnt_q;
        in_sr_d     = in_sr_q;
        ptr_d       = ptr_q;
        jedec_idx_d = jedec_idx_q;
        fetch_d     = 1'b0;
        load_d      = load_q;
        byte_d      = byte_q;
        out_sr_d    = out_sr_q;
        cipo_d      = cipo_o;
        cipo_en_d   = cipo_en_o;
        last_cmd_d  = last_cmd_o;
        cmd_err_d   = 1'b0;
        rd_byte     = 8'h00;
        rx_word     = {in_sr_q, copi_s};

        // Byte fetch, one cycle after the edge that completed the previous field
        if (fetch_q) begin
            case (src_q)
                SRC_JEDEC: begin
                    case (jedec_idx_q)
                        2'd0:    rd_byte = JedecId[23:16];
                        2'd1:    rd_byte = JedecId[15:8];
                        2'd2:    rd_byte = JedecId[7:0];
                        default: rd_byte = 8'h00;
                    endcase
                    if (jedec_idx_q != 2'd3) begin
                        jedec_idx_d = 2'(jedec_idx_q + 2'd1);
                    end
                end
                SRC_STATUS: rd_byte = StatusVal;
                default: begin
                    rd_byte = mem[ptr_q];
                    ptr_d   = AddrW'(ptr_q + AddrW'(1));
                end
            endcase
            byte_d = rd_byte;
            load_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    in_sr_d   = '0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    in_sr_d = rx_word[AddrBits-2:0];
                    if (bit_cnt_q == CntW'(CmdBits - 1)) begin
                        bit_cnt_d  = '0;
                        last_cmd_d = rx_word[7:0];
                        case (rx_word[7:0])
                            CmdReadJedec: begin
                                state_d     = DATA;
                                src_d       = SRC_JEDEC;
                                jedec_idx_d = '0;
                                fetch_d     = 1'b1;
                            end
                            CmdReadStatus: begin
                                state_d = DATA;
                                src_d   = SRC_STATUS;
                                fetch_d = 1'b1;
                            end
                            CmdRead: begin
                                state_d = ADDR;
                            end
                            default: begin
                                state_d   = IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_cnt_d = CntW'(bit_cnt_q + CntW'(1));
                    end
                end
            end
            ADDR: begin
                if (sck_rise) begin
                    in_sr_d = rx_word[AddrBits-2:0];
                    if (bit_cnt_q == CntW'(AddrBits - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                        src_d     = SRC_MEM;
                        ptr_d     = AddrW'(rx_word);
                        fetch_d   = 1'b1;
                    end else begin
                        bit_cnt_d = CntW'(bit_cnt_q + CntW'(1));
                    end
                end
            end
            DATA: begin
                if (sck_rise) begin
                    if (bit_cnt_q == CntW'(ByteBits - 1)) begin
                        bit_cnt_d = '0;
                        fetch_d   = 1'b1;
                    end else begin
                        bit_cnt_d = CntW'(bit_cnt_q + CntW'(1));
                    end
                end
                if (sck_fall) begin
                    if (load_q) begin
                        cipo_d    = byte_q[7];
                        out_sr_d  = {byte_q[6:0], 1'b0};
                        cipo_en_d = 1'b1;
                        load_d    = 1'b0;
                    end else begin
                        cipo_d   = out_sr_q[7];
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                    end
                end
            end
            default: begin
                cipo_en_d = 1'b0;
            end
        endcase

        // Deselect wins over everything, including a partially shifted opcode
        if (cs_rise) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            in_sr_d     = '0;
            jedec_idx_d = '0;
            fetch_d     = 1'b0;
            load_d      = 1'b0;
            out_sr_d    = '0;
            cipo_d      = 1'b0;
            cipo_en_d   = 1'b0;
            last_cmd_d  = last_cmd_o;
            cmd_err_d   = 1'b0;
        end

        busy_d = (state_d != IDLE) && !cs_s;
    end

endmodule

// File: tb/tb_spi_flash_model.sv
// Scoreboarded bench for spi_flash_model: a host driver pushes expected read bytes,
// a monitor reassembles cipo bytes on sck rising edges and compares them.
module tb_spi_flash_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        copi = 1'b0;
    logic        cipo;
    logic        cipo_en;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [7:0]  mem_wdata = '0;
    logic        busy;
    logic [7:0]  last_cmd;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    bit en_seen = 1'b0;
    logic [7:0] exp_q[$];

    spi_flash_model dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sck_i       (sck),
        .cs_ni       (cs_n),
        .copi_i      (copi),
        .cipo_o      (cipo),
        .cipo_en_o   (cipo_en),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .busy_o      (busy),
        .last_cmd_o  (last_cmd),
        .cmd_err_o   (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err) err_pulses++;
        if (cipo_en) en_seen = 1'b1;
    end

    // Monitor: host-side byte assembly, compared against the expected-byte queue
    initial begin : monitor
        logic [7:0] sh;
        logic [7:0] e;
        int nb;
        sh = '0;
        nb = 0;
        forever begin
            @(posedge sck or posedge cs_n or negedge rst_n);
            if (cs_n || !rst_n) begin
                nb = 0;
            end else if (cipo_en) begin
                sh = {sh[6:0], cipo};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL cipo_byte: got %h, no byte expected", sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e) begin
                            errors++;
                            $display("FAIL cipo_byte: got %h, expected %h", sh, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic sck_bit(input logic b);
        copi = b;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(8);
        sck = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sck_bit(b[i]);
    endtask

    task automatic read_bytes(input int n);
        repeat (n * 8) sck_bit(1'b0);
    endtask

    task automatic cs_assert();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_release();
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        wait_clk(1);
        mem_we    = 1'b0;
    endtask

    task automatic read_cmd(input logic [23:0] a);
        send_byte(8'h03);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    initial begin : stimulus
        int p;
        @(negedge clk);
        wait_clk(3);
        check("reset_cipo",     32'(cipo),     32'd0);
        check("reset_cipo_en",  32'(cipo_en),  32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_last_cmd", 32'(last_cmd), 32'h00);
        check("reset_cmd_err",  32'(cmd_err),  32'd0);
        rst_n = 1'b1;
        wait_clk(3);

        mem_write(16'h0100, 8'h11);
        mem_write(16'h0101, 8'h22);
        mem_write(16'h0102, 8'h33);
        mem_write(16'h0103, 8'h44);
        mem_write(16'hFFFF, 8'hA5);
        mem_write(16'h0000, 8'h5A);

        // JEDEC ID
        cs_assert();
        check("busy_selected", 32'(busy), 32'd1);
        check("en_before_op",  32'(cipo_en), 32'd0);
        send_byte(8'h9F);
        check("en_after_jedec_op", 32'(cipo_en), 32'd1);
        check("last_cmd_jedec",    32'(last_cmd), 32'h9F);
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
        exp_q.push_back(8'h18); exp_q.push_back(8'h00);
        read_bytes(4);
        cs_release();
        check("busy_deselected",   32'(busy),    32'd0);
        check("en_deselected",     32'(cipo_en), 32'd0);
        check("cipo_deselected",   32'(cipo),    32'd0);

        // Memory read
        cs_assert();
        read_cmd(24'h000100);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        read_bytes(4);
        check("last_cmd_read", 32'(last_cmd), 32'h03);
        cs_release();

        // Address wrap and upper-bit aliasing
        cs_assert();
        read_cmd(24'h00FFFF);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        read_bytes(2);
        cs_release();
        cs_assert();
        read_cmd(24'h12FFFF);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        read_bytes(2);
        cs_release();

        // Status
        cs_assert();
        send_byte(8'h05);
        check("en_after_status_op", 32'(cipo_en), 32'd1);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        read_bytes(3);
        check("last_cmd_status", 32'(last_cmd), 32'h05);
        cs_release();

        // Unsupported opcode
        en_seen = 1'b0;
        p = err_pulses;
        cs_assert();
        send_byte(8'h42);
        read_bytes(1);
        check("cmd_err_pulses", 32'(err_pulses - p), 32'd1);
        check("en_unknown",     32'(en_seen),        32'd0);
        check("last_cmd_unknown", 32'(last_cmd),     32'h42);
        cs_release();

        // Abort after a partial opcode
        cs_assert();
        sck_bit(1'b1); sck_bit(1'b0); sck_bit(1'b0); sck_bit(1'b1);
        cs_release();
        check("last_cmd_abort", 32'(last_cmd), 32'h42);
        check("busy_abort",     32'(busy),     32'd0);
        cs_assert();
        send_byte(8'h9F);
        exp_q.push_back(8'hEF);
        read_bytes(1);
        cs_release();

        // Reset during DATA, then cs held low across release
        cs_assert();
        send_byte(8'h9F);
        exp_q.push_back(8'hEF);
        read_bytes(1);
        sck_bit(1'b0); sck_bit(1'b0); sck_bit(1'b0);
        rst_n = 1'b0;
        wait_clk(2);
        check("rst_cipo",     32'(cipo),     32'd0);
        check("rst_cipo_en",  32'(cipo_en),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_last_cmd", 32'(last_cmd), 32'h00);
        check("rst_cmd_err",  32'(cmd_err),  32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        send_byte(8'h9F);
        read_bytes(1);
        check("post_rst_busy",     32'(busy),     32'd0);
        check("post_rst_cipo_en",  32'(cipo_en),  32'd0);
        check("post_rst_last_cmd", 32'(last_cmd), 32'h00);
        cs_release();
        cs_assert();
        send_byte(8'h9F);
        exp_q.push_back(8'hEF);
        read_bytes(1);
        cs_release();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_model.md
Name: spi_flash_model

Overview:
- Synthesisable RTL SPI flash target: the responder end of the host's application SPI flash port.
- Replaces the flash DPI model in simulation benches that need cycle-accurate, self-contained flash behaviour.
- Oversamples sck/cs/copi on the system clock and answers JEDEC ID, read-status and read commands from an internal byte array.
- The byte array is preloaded through a backdoor write port.

Parameters:
- MemBytes, 65536, size of backing byte array; power of two.
- AddrW, $clog2(MemBytes), width of the internal byte address.
- JedecId, 24'hEF4018, bytes returned by 0x9F, MSB byte first.
- StatusVal, 8'h00, value returned by 0x05; WIP=0 always.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- sck_i  in  1  SPI clock from host, asynchronous to clk_i; idle low, mode 0.
- cs_ni  in  1  chip select, active low.
- copi_i  in  1  host-to-target data.
- cipo_o  out  1  target-to-host data.
- cipo_en_o  out  1  high while the target drives cipo_o.
- mem_we_i  in  1  backdoor byte write strobe.
- mem_addr_i  in  AddrW  backdoor write address.
- mem_wdata_i  in  8  backdoor write data.
- busy_o  out  1  high while a transaction is selected (cs_ni low, synchronised).
- last_cmd_o  out  8  opcode of the most recent completed command byte.
- cmd_err_o  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset values: cipo_o=0, cipo_en_o=0, busy_o=0, last_cmd_o=8'h00, cmd_err_o=0, FSM=IDLE. Array contents are not reset.
- Sync: sck_i, cs_ni and copi_i each pass through 2 flops. Edges are detected on the synchronised sck and cs.
- Timing requirement: sck high and low phases are each >=4 clk_i cycles. Faster sck is outside the spec.
- Sampling: copi is sampled on sck rising edges. cipo updates on sck falling edges. All data is MSB first.
- FSM states:
  - IDLE -> CMD on cs falling edge. busy_o rises 1 cycle after the synchronised cs falls.
  - CMD: 8 rising edges shift in the opcode. On the 8th rising edge, last_cmd_o is updated and:
    - 0x9F -> DATA, source=JEDEC, byte idx 0.
    - 0x05 -> DATA, source=STATUS.
    - 0x03 -> ADDR, bit count cleared.
    - other -> IGNORE, with cmd_err_o pulsed for 1 cycle.
  - ADDR: 24 rising edges. The low AddrW bits of the 24-bit address are kept; upper bits are ignored (aliasing). After the 24th edge -> DATA, source=MEM.
  - DATA: the next byte is fetched 1 cycle after the rising edge that completes the previous byte or command/address. It is loaded into the shift register on the following sck falling edge, which also drives bit 7 and sets cipo_en_o=1. Each subsequent falling edge shifts one bit out.
    - JEDEC: bytes 23:16, 15:8, 7:0, then 8'h00 for every further byte.
    - STATUS: StatusVal repeated indefinitely.
    - MEM: byte at the current address, then address+1 mod MemBytes (wraps MemBytes-1 -> 0).
    - copi is ignored in DATA.
  - IGNORE: cipo_en_o=0; waits for cs rising.
- cs rising edge in any state, including mid-byte: -> IDLE in the same cycle. cipo_en_o=0, cipo_o=0, busy_o=0, counters cleared. A partial opcode does not update last_cmd_o.
- Backdoor write: mem[mem_addr_i] <= mem_wdata_i on the cycle mem_we_i is high. It is allowed at any time. A write in the same cycle as a fetch of the same address is not visible to that fetch (old data is returned).
- Reset asserted mid-transaction: all outputs return to reset values immediately. After release the FSM stays in IDLE until a fresh cs falling edge; a cs already low at release is ignored until it rises.

Decomposition:
- spi_flash_model_pkg holds:
  - opcode constants CmdReadJedec=8'h9F, CmdReadStatus=8'h05, CmdRead=8'h03;
  - state enum {IDLE, CMD, ADDR, DATA, IGNORE};
  - data-source enum {SRC_JEDEC, SRC_STATUS, SRC_MEM}.
- One sub-module, spi_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs, instantiated for sck and cs. copi uses its plain synchroniser only.

Test Plan:
- JEDEC: cs low, send 0x9F, clock 32 bits -> cipo bytes EF,40,18,00. cipo_en_o is high from the first falling edge after the opcode. last_cmd_o=9F.
- Read: preload mem[0x0100..0x0103]=11,22,33,44; send 03 00 01 00, clock 32 bits -> 11,22,33,44.
- Wrap: MemBytes=65536, preload mem[FFFF]=A5, mem[0000]=5A; read at 0x00FFFF for 2 bytes -> A5,5A. Address 0x12FFFF aliases to the same result.
- Status/unknown: 0x05 clocked 3 bytes -> 00,00,00. Opcode 0x42 -> cmd_err_o one pulse, cipo_en_o stays 0, last_cmd_o=42.
- Abort: raise cs after 4 opcode bits, then issue a new 0x9F -> correct EF first byte, and last_cmd_o unchanged by the aborted opcode. Reset pulse during DATA -> all outputs return to 0 within the reset assertion.
